// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with count, programmable flags and standard/FWFT read modes
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       wr_error,
  output logic                       rd_error
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q, wr_err_q, rd_err_q;
  logic             wr_acc, rd_acc;
  // acceptance uses the registered flags, so a same-cycle read never frees room for a write
  always_comb begin
    wr_acc  = wr_en && !full_q;
    rd_acc  = rd_en && !empty_q;
    count_d = (wr_acc && !rd_acc) ? count_q + CW'(1) :
              (rd_acc && !wr_acc) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      count_q  <= count_d;
      full_q   <= count_d == CW'(DEPTH);
      empty_q  <= count_d == '0;
      af_q     <= count_d >= CW'(AF_THRESH);
      ae_q     <= count_d <= CW'(AE_THRESH);
      wr_err_q <= wr_en && full_q;
      rd_err_q <= rd_en && empty_q;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end
  if (FWFT != 0) begin : g_fwft
    assign rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = !empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
    end
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign wr_error     = wr_err_q;
  assign rd_error     = rd_err_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: standard and FWFT FIFOs driven in lockstep and checked against a queue model
module tb_sync_fifo_param;
  localparam int W = 8, D = 6, AF = 5, AE = 1;
  logic clk = 1'b0, rst, wr_en, rd_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] s_data, f_data;
  logic s_valid, f_valid;
  logic s_full, s_empty, s_af, s_ae, s_werr, s_rerr;
  logic f_full, f_empty, f_af, f_ae, f_werr, f_rerr;
  logic [2:0] s_count, f_count;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_std_data;
  logic m_std_valid, m_werr, m_rerr;
  always #5 clk = ~clk;
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_data), .rd_valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .wr_error(s_werr), .rd_error(s_rerr));
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_data), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .wr_error(f_werr), .rd_error(f_rerr));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    chk("s_count", 32'(s_count), 32'(n));
    chk("f_count", 32'(f_count), 32'(n));
    chk("s_full", 32'(s_full), 32'(n == D));
    chk("f_full", 32'(f_full), 32'(n == D));
    chk("s_empty", 32'(s_empty), 32'(n == 0));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("s_af", 32'(s_af), 32'(n >= AF));
    chk("f_af", 32'(f_af), 32'(n >= AF));
    chk("s_ae", 32'(s_ae), 32'(n <= AE));
    chk("f_ae", 32'(f_ae), 32'(n <= AE));
    chk("s_wr_error", 32'(s_werr), 32'(m_werr));
    chk("f_wr_error", 32'(f_werr), 32'(m_werr));
    chk("s_rd_error", 32'(s_rerr), 32'(m_rerr));
    chk("f_rd_error", 32'(f_rerr), 32'(m_rerr));
    chk("s_rd_valid", 32'(s_valid), 32'(m_std_valid));
    chk("s_rd_data", 32'(s_data), 32'(m_std_data));
    chk("f_rd_valid", 32'(f_valid), 32'(n != 0));
    if (n != 0) chk("f_rd_data", 32'(f_data), 32'(q[0]));
  endtask
  // one clock: drive, let the edge happen, advance the model, then compare
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input logic rs = 1'b0);
    bit was_full, was_empty;
    rst = rs; wr_en = w; rd_en = r; wr_data = d;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_std_data = '0; m_std_valid = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;
    end else begin
      was_full = q.size() == D;
      was_empty = q.size() == 0;
      m_werr = w && was_full;
      m_rerr = r && was_empty;
      m_std_valid = r && !was_empty;
      if (r && !was_empty) m_std_data = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    #1;
    check_all();
  endtask
  initial begin
    m_std_data = '0; m_std_valid = 1'b0; m_werr = 1'b0; m_rerr = 1'b0;
    cycle(1, 1, 8'hFF, 1);
    cycle(1, 1, 8'hEE, 1);
    for (int i = 1; i <= 7; i++) cycle(1, 0, W'(i));
    cycle(0, 0, 8'h00);
    for (int i = 0; i < 7; i++) cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1, 0, W'(8'h10 + i));
    for (int i = 0; i < 20; i++) cycle(1, 1, W'(8'h20 + i));
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00);
    cycle(1, 1, 8'hA5);
    for (int i = 0; i < 5; i++) cycle(1, 0, W'(8'h50 + i));
    cycle(1, 1, 8'h77);
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h3C);
    cycle(0, 0, 8'h00);
    cycle(0, 1, 8'h00);
    cycle(0, 0, 8'h00);
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
            W'($urandom), 1'($urandom_range(0, 99) == 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
